// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with optional hard-zero register, write bypass
// and a per-register pending scoreboard; all state updates on the falling edge of Clk.
module regfile_sb #(
   parameter int WIDTH    = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_EN  = 1,
   parameter int ZERO_REG = 31,
   parameter int BYPASS   = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   output logic [WIDTH-1:0]  BusA,
   output logic [WIDTH-1:0]  BusB,
   input  logic [ADDR_W-1:0] RW,
   input  logic [WIDTH-1:0]  BusW,
   input  logic              RegWr,
   input  logic              Issue,
   input  logic [ADDR_W-1:0] IssueReg,
   output logic              PendA,
   output logic              PendB,
   output logic [ADDR_W:0]   PendCnt
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
   localparam logic Z = ZERO_EN != 0;
   localparam logic B = BYPASS != 0;
   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] pend;
   logic [ADDR_W:0] cnt;
   logic wr_ok, set_ok, set_new, clr_hit, zero_a, zero_b, byp_a, byp_b;
   always_comb begin
      wr_ok   = RegWr && !(Z && RW == ZR);
      set_ok  = Issue && !(Z && IssueReg == ZR);
      set_new = set_ok && !pend[IssueReg];
      // a same-index issue supersedes the completing writeback, so no decrement then
      clr_hit = RegWr && pend[RW] && !(set_ok && IssueReg == RW);
      zero_a  = Z && RA == ZR;
      zero_b  = Z && RB == ZR;
      byp_a   = B && RegWr && RW == RA;
      byp_b   = B && RegWr && RW == RB;
      BusA    = zero_a ? '0 : byp_a ? BusW : regs[RA];
      BusB    = zero_b ? '0 : byp_b ? BusW : regs[RB];
      PendA   = !zero_a && !byp_a && pend[RA];
      PendB   = !zero_b && !byp_b && pend[RB];
      PendCnt = cnt;
   end
   always_ff @(negedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         pend <= '0;
         cnt  <= '0;
      end else begin
         if (wr_ok) regs[RW] <= BusW;
         if (RegWr) pend[RW] <= 1'b0;
         if (set_ok) pend[IssueReg] <= 1'b1;
         cnt <= cnt + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_hit};
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb with bypass on (dut) and off (dut_nb).
module tb_regfile_sb;
   logic        Clk = 1'b1;
   logic        Reset = 1'b0;
   logic [4:0]  RA = '0, RB = '0, RW = '0, IssueReg = '0;
   logic [63:0] BusW = '0;
   logic        RegWr = 1'b0, Issue = 1'b0;
   logic [63:0] BusA, BusB, nb_BusA, nb_BusB;
   logic        PendA, PendB, nb_PendA, nb_PendB;
   logic [5:0]  PendCnt, nb_PendCnt;
   int pass_cnt = 0, tot = 0;

   always #5 Clk = ~Clk;

   regfile_sb dut (.Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
      .RW(RW), .BusW(BusW), .RegWr(RegWr), .Issue(Issue), .IssueReg(IssueReg),
      .PendA(PendA), .PendB(PendB), .PendCnt(PendCnt));
   regfile_sb #(.BYPASS(0)) dut_nb (.Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .BusA(nb_BusA),
      .BusB(nb_BusB), .RW(RW), .BusW(BusW), .RegWr(RegWr), .Issue(Issue), .IssueReg(IssueReg),
      .PendA(nb_PendA), .PendB(nb_PendB), .PendCnt(nb_PendCnt));

   // inputs change just after a falling edge and stay stable until the next one
   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      Reset = 1'b0; RA = 5'd3; RB = 5'd31;
      #1;
      tot++; if (BusA !== 64'h0) $display("FAIL reset_busa got %h exp 0", BusA); else pass_cnt++;
      tot++; if (BusB !== 64'h0) $display("FAIL reset_busb got %h exp 0", BusB); else pass_cnt++;
      tot++; if (PendA !== 1'b0) $display("FAIL reset_penda got %b exp 0", PendA); else pass_cnt++;
      tot++; if (PendB !== 1'b0) $display("FAIL reset_pendb got %b exp 0", PendB); else pass_cnt++;
      tot++; if (PendCnt !== 6'd0) $display("FAIL reset_cnt got %0d exp 0", PendCnt); else pass_cnt++;
      tot++; if (nb_PendCnt !== 6'd0) $display("FAIL reset_nb_cnt got %0d exp 0", nb_PendCnt); else pass_cnt++;
   endtask

   task automatic test_bypass();
      RW = 5'd5; BusW = 64'hDEAD_BEEF_0123_4567; RegWr = 1'b1; RA = 5'd5;
      #1;
      tot++; if (BusA !== 64'hDEAD_BEEF_0123_4567) $display("FAIL bypass_pre got %h exp deadbeef01234567", BusA); else pass_cnt++;
      tot++; if (nb_BusA !== 64'h0) $display("FAIL nobypass_pre got %h exp 0", nb_BusA); else pass_cnt++;
      tick();
      RegWr = 1'b0; BusW = '0;
      #1;
      tot++; if (BusA !== 64'hDEAD_BEEF_0123_4567) $display("FAIL bypass_post got %h exp deadbeef01234567", BusA); else pass_cnt++;
      tot++; if (nb_BusA !== 64'hDEAD_BEEF_0123_4567) $display("FAIL nobypass_post got %h exp deadbeef01234567", nb_BusA); else pass_cnt++;
   endtask

   task automatic test_zero_reg();
      RW = 5'd31; BusW = '1; RegWr = 1'b1; RA = 5'd31;
      #1;
      tot++; if (BusA !== 64'h0) $display("FAIL zero_bypass got %h exp 0", BusA); else pass_cnt++;
      tick();
      RegWr = 1'b0; Issue = 1'b1; IssueReg = 5'd31;
      tick();
      Issue = 1'b0;
      #1;
      tot++; if (BusA !== 64'h0) $display("FAIL zero_read got %h exp 0", BusA); else pass_cnt++;
      tot++; if (PendA !== 1'b0) $display("FAIL zero_pend got %b exp 0", PendA); else pass_cnt++;
      tot++; if (PendCnt !== 6'd0) $display("FAIL zero_cnt got %0d exp 0", PendCnt); else pass_cnt++;
   endtask

   task automatic test_scoreboard();
      Issue = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         IssueReg = 5'(i);
         tick();
      end
      Issue = 1'b0; RA = 5'd1;
      #1;
      tot++; if (PendCnt !== 6'd3) $display("FAIL sb_cnt3 got %0d exp 3", PendCnt); else pass_cnt++;
      tot++; if (PendA !== 1'b1) $display("FAIL sb_penda1 got %b exp 1", PendA); else pass_cnt++;
      RW = 5'd2; BusW = 64'h22; RegWr = 1'b1; RA = 5'd2;
      #1;
      tot++; if (PendA !== 1'b0) $display("FAIL sb_bypass_pend got %b exp 0", PendA); else pass_cnt++;
      tot++; if (nb_PendA !== 1'b1) $display("FAIL sb_nobypass_pend got %b exp 1", nb_PendA); else pass_cnt++;
      tick();
      RegWr = 1'b0;
      #1;
      tot++; if (PendCnt !== 6'd2) $display("FAIL sb_cnt2 got %0d exp 2", PendCnt); else pass_cnt++;
      tot++; if (nb_PendA !== 1'b0) $display("FAIL sb_clear got %b exp 0", nb_PendA); else pass_cnt++;
      tot++; if (nb_BusA !== 64'h22) $display("FAIL sb_data got %h exp 22", nb_BusA); else pass_cnt++;
   endtask

   task automatic test_same_edge();
      Issue = 1'b1; IssueReg = 5'd7;
      tick();
      RegWr = 1'b1; RW = 5'd7; BusW = 64'h77;
      tick();
      Issue = 1'b0; RegWr = 1'b0; RA = 5'd7;
      #1;
      tot++; if (PendA !== 1'b1) $display("FAIL same_pend got %b exp 1", PendA); else pass_cnt++;
      tot++; if (PendCnt !== 6'd3) $display("FAIL same_cnt got %0d exp 3", PendCnt); else pass_cnt++;
      tot++; if (BusA !== 64'h77) $display("FAIL same_data got %h exp 77", BusA); else pass_cnt++;
      Issue = 1'b1; IssueReg = 5'd1; RegWr = 1'b1; RW = 5'd3; BusW = 64'h33;
      tick();
      Issue = 1'b0; RegWr = 1'b0; RA = 5'd1; RB = 5'd3;
      #1;
      tot++; if (PendCnt !== 6'd2) $display("FAIL reissue_cnt got %0d exp 2", PendCnt); else pass_cnt++;
      tot++; if (PendA !== 1'b1) $display("FAIL reissue_pend got %b exp 1", PendA); else pass_cnt++;
      tot++; if (PendB !== 1'b0) $display("FAIL clear3_pend got %b exp 0", PendB); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      Issue = 1'b1;
      for (int i = 8; i <= 15; i++) begin
         IssueReg = 5'(i);
         tick();
      end
      Issue = 1'b0;
      #1;
      tot++; if (PendCnt !== 6'd10) $display("FAIL fill10_cnt got %0d exp 10", PendCnt); else pass_cnt++;
      Reset = 1'b1; RegWr = 1'b1; RW = 5'd4; BusW = 64'h55; Issue = 1'b1; IssueReg = 5'd9;
      tick();
      Reset = 1'b0; RegWr = 1'b0; Issue = 1'b0; RA = 5'd4; RB = 5'd9;
      #1;
      tot++; if (PendCnt !== 6'd0) $display("FAIL rmid_cnt got %0d exp 0", PendCnt); else pass_cnt++;
      tot++; if (BusA !== 64'h0) $display("FAIL rmid_reg4 got %h exp 0", BusA); else pass_cnt++;
      tot++; if (PendB !== 1'b0) $display("FAIL rmid_pend9 got %b exp 0", PendB); else pass_cnt++;
      RA = 5'd5; RB = 5'd7;
      #1;
      tot++; if (BusA !== 64'h0) $display("FAIL rmid_reg5 got %h exp 0", BusA); else pass_cnt++;
      tot++; if (PendB !== 1'b0) $display("FAIL rmid_pend7 got %b exp 0", PendB); else pass_cnt++;
   endtask

   task automatic test_full();
      Issue = 1'b1;
      for (int i = 0; i < 32; i++) begin
         IssueReg = 5'(i);
         tick();
      end
      IssueReg = 5'd5;
      tick();
      Issue = 1'b0; RA = 5'd0; RB = 5'd30;
      #1;
      tot++; if (PendCnt !== 6'd31) $display("FAIL full_cnt got %0d exp 31", PendCnt); else pass_cnt++;
      tot++; if (PendA !== 1'b1 || PendB !== 1'b1) $display("FAIL full_pend got %b%b exp 11", PendA, PendB); else pass_cnt++;
      RegWr = 1'b1; RW = 5'd0; Issue = 1'b1; IssueReg = 5'd31;
      tick();
      RegWr = 1'b0; Issue = 1'b0;
      #1;
      tot++; if (PendCnt !== 6'd30) $display("FAIL full_dec_cnt got %0d exp 30", PendCnt); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_zero_reg();
      test_scoreboard();
      test_same_edge();
      test_reset_mid();
      test_full();
      $display("%0d/%0d checks passed", pass_cnt, tot);
      $finish;
   end
endmodule
